sr_line_doubler: RTL and testbench



---
 rtl/sr_line_doubler.sv | 124 ++++++++++++
 tb/tb_sr_line_doubler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_line_doubler.sv
// rtl/sr_line_doubler.sv - one-line buffer emitting a 2x nearest-neighbour upscaled RGB565 stream
module sr_line_doubler #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIXEL_WIDTH = 24,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk_w,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] fifo_dout,
  input  logic [COUNT_WIDTH-1:0] fifo_count,
  output logic                   fifo_rd,
  output logic [15:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int XW = AW + 1;
  localparam int LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST    = XW'(2 * WIDTH - 1);
  localparam logic [CW-1:0] RD_MAX    = CW'(WIDTH);
  localparam logic [LW-1:0] LINE_LAST = LW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] in_x;
  logic [CW-1:0] rd_cnt;
  logic          rd_q;
  logic [XW-1:0] out_x, out_x_nxt;
  logic          rep;
  logic [LW-1:0] line;
  logic          primed;
  logic [15:0]   linebuf [0:WIDTH-1];
  logic [15:0]   rdata;
  logic [15:0]   pix565;
  logic          accept, x_last, wr_en;
  logic          dout_unused;

  assign pix565      = {fifo_dout[23:19], fifo_dout[15:10], fifo_dout[7:3]};
  assign dout_unused = ^{fifo_dout[18:16], fifo_dout[9:8], fifo_dout[2:0]};
  assign accept      = out_valid && out_ready;
  assign x_last      = (out_x == X_LAST);
  assign wr_en       = (state == FILL) && rd_q;

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fifo_count != '0) state_nxt = FILL;
      FILL: if (rd_q && in_x == AW'(WIDTH - 1)) state_nxt = EMIT;
      EMIT: if (accept && x_last && rep) state_nxt = (line == LINE_LAST) ? DONE : FILL;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The read just issued may not be reflected in fifo_count yet, so it is held back from the occupancy.
  always_comb begin
    fifo_rd    = (state == FILL) && (rd_cnt < RD_MAX) &&
                 (fifo_count > {{(COUNT_WIDTH-1){1'b0}}, rd_q});
    out_valid  = (state == EMIT) && primed;
    out_sof    = out_valid && (out_x == '0) && !rep && (line == '0);
    out_eol    = out_valid && x_last;
    out_data   = out_valid ? rdata : 16'h0000;
    frame_done = (state == DONE);
    busy       = (state != IDLE);
  end

  // Read address follows the post-edge out_x, so rdata always matches the presented pixel.
  always_comb begin
    out_x_nxt = out_x;
    if (state != EMIT)  out_x_nxt = '0;
    else if (accept)    out_x_nxt = x_last ? '0 : out_x + 1'b1;
  end

  always_ff @(posedge clk_w) begin
    if (wr_en) linebuf[in_x] <= pix565;
    rdata <= linebuf[out_x_nxt[XW-1:1]];
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      in_x   <= '0;
      rd_cnt <= '0;
      rd_q   <= 1'b0;
      out_x  <= '0;
      rep    <= 1'b0;
      line   <= '0;
      primed <= 1'b0;
    end else begin
      rd_q   <= fifo_rd;
      out_x  <= out_x_nxt;
      primed <= (state == EMIT) && (state_nxt == EMIT);
      if (state == FILL) begin
        if (fifo_rd) rd_cnt <= rd_cnt + 1'b1;
        if (rd_q)    in_x   <= in_x + 1'b1;
      end else begin
        rd_cnt <= '0;
        in_x   <= '0;
      end
      if (state == EMIT && accept && x_last) begin
        if (!rep) begin
          rep <= 1'b1;
        end else begin
          rep <= 1'b0;
          if (line != LINE_LAST) line <= line + 1'b1;
        end
      end
      if (state == DONE) line <= '0;
    end
  end

endmodule

// File: tb/tb_sr_line_doubler.sv
// tb/tb_sr_line_doubler.sv - directed self-checking bench for sr_line_doubler
module tb_sr_line_doubler;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = 10;

  logic          clk_w = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_rd;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sof, out_eol, frame_done, busy;

  always #5 clk_w = ~clk_w;

  sr_line_doubler #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(24), .COUNT_WIDTH(CW)) dut (
    .clk_w(clk_w), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_count(fifo_count),
    .fifo_rd(fifo_rd), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done), .busy(busy)
  );

  // FIFO model: occupancy is registered, so it drops on the edge after a read
  logic [23:0] src [0:127];
  int wr_ptr = 0, rd_ptr = 0, fifo_level = 0, underflow = 0, nrd;
  assign fifo_count = CW'(fifo_level);

  always @(posedge clk_w) begin
    nrd = rd_ptr;
    if (fifo_rd) begin
      if (rd_ptr < wr_ptr) begin
        fifo_dout <= src[rd_ptr];
        nrd = rd_ptr + 1;
      end else begin
        underflow <= underflow + 1;
      end
    end
    rd_ptr     <= nrd;
    fifo_level <= wr_ptr - nrd;
  end

  logic [15:0] cap_d [0:511];
  logic        cap_s [0:511];
  logic        cap_e [0:511];
  int n_acc = 0, n_sof = 0, n_eol = 0, n_done = 0;
  int stall_viol = 0, rd_in_emit = 0, max_gap = 0, gap = 0;
  logic in_line = 1'b0, prev_stall = 1'b0, prev_s = 1'b0, prev_e = 1'b0;
  logic [15:0] prev_d = 16'h0;

  always @(posedge clk_w) begin
    if (!rst_n) begin
      in_line    <= 1'b0;
      prev_stall <= 1'b0;
      gap        <= 0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_d || out_sof !== prev_s || out_eol !== prev_e))
        stall_viol <= stall_viol + 1;
      prev_stall <= out_valid && !out_ready;
      prev_d     <= out_data;
      prev_s     <= out_sof;
      prev_e     <= out_eol;
      if (fifo_rd && out_valid) rd_in_emit <= rd_in_emit + 1;
      if (frame_done) n_done <= n_done + 1;
      if (out_valid && out_ready) begin
        if (n_acc < 512) begin
          cap_d[n_acc] <= out_data;
          cap_s[n_acc] <= out_sof;
          cap_e[n_acc] <= out_eol;
        end
        n_acc   <= n_acc + 1;
        n_sof   <= n_sof + (out_sof ? 1 : 0);
        n_eol   <= n_eol + (out_eol ? 1 : 0);
        in_line <= !out_eol;
        gap     <= 0;
      end else if (in_line && !out_valid) begin
        gap <= gap + 1;
        if (gap + 1 > max_gap) max_gap <= gap + 1;
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] p);
    src[wr_ptr] = p;
    wr_ptr++;
  endtask

  function automatic logic [15:0] conv(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  task automatic wait_done(input int tgt, input int budget, input string tag);
    for (int c = 0; c < budget && n_done < tgt; c++) @(negedge clk_w);
    check(tag, 32'(n_done), 32'(tgt));
  endtask

  task automatic check_frame(input int b, input int sb, input string tag);
    for (int k = 0; k < 32; k++) begin
      int x, idx;
      x   = k % 8;
      idx = sb + (k / 16) * 4 + x / 2;
      check($sformatf("%s_d%0d", tag, k), 32'(cap_d[b + k]), 32'(conv(src[idx])));
      check($sformatf("%s_s%0d", tag, k), 32'(cap_s[b + k]), 32'(k == 0));
      check($sformatf("%s_e%0d", tag, k), 32'(cap_e[b + k]), 32'(x == 7));
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"},  32'(out_data),  0);
    check({tag, "_sof"},   32'(out_sof),   0);
    check({tag, "_eol"},   32'(out_eol),   0);
    check({tag, "_rd"},    32'(fifo_rd),   0);
    check({tag, "_done"},  32'(frame_done), 0);
    check({tag, "_busy"},  32'(busy),      0);
  endtask

  logic [23:0] p1  [0:3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
  logic [15:0] e1  [0:3] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
  logic [23:0] p3  [0:7] = '{24'h87C3F9, 24'h123456, 24'hABCDEF, 24'h00FF00,
                             24'h808080, 24'h7F7F7F, 24'h0F0F0F, 24'hF0F0F0};

  initial begin
    int b, sb, d, s, e, viol;

    repeat (3) @(negedge clk_w);
    check_outs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk_w);

    // basic frame, consumer always ready
    b = n_acc; d = n_done; s = n_sof; e = n_eol;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(p1[i % 4]);
    wait_done(d + 1, 600, "t1_done");
    check("t1_acc", 32'(n_acc - b), 32);
    check("t1_sof", 32'(n_sof - s), 1);
    check("t1_eol", 32'(n_eol - e), 4);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("t1_d%0d", k), 32'(cap_d[b + k]), 32'(e1[(k % 8) / 2]));
      check($sformatf("t1_s%0d", k), 32'(cap_s[b + k]), 32'(k == 0));
      check($sformatf("t1_e%0d", k), 32'(cap_e[b + k]), 32'(k % 8 == 7));
    end
    check("t1_idle", 32'(busy), 0);

    // pseudo-random backpressure
    b = n_acc; d = n_done; sb = wr_ptr;
    for (int i = 0; i < 8; i++) push(p1[i % 4]);
    for (int c = 0; c < 3000 && n_done < d + 1; c++) begin
      @(negedge clk_w);
      out_ready = 1'($urandom_range(0, 1));
    end
    check("t2_done", 32'(n_done), 32'(d + 1));
    out_ready = 1'b1;
    check("t2_acc", 32'(n_acc - b), 32);
    check_frame(b, sb, "t2");
    check("t2_stall", 32'(stall_viol), 0);

    // starvation after two pixels, plus conversion of 0x87C3F9
    b = n_acc; d = n_done; sb = wr_ptr;
    push(p3[0]);
    push(p3[1]);
    repeat (10) @(negedge clk_w);
    viol = 0;
    repeat (50) begin
      @(negedge clk_w);
      if (fifo_rd || out_valid) viol++;
    end
    check("t3_starve", 32'(viol), 0);
    check("t3_busy", 32'(busy), 1);
    for (int i = 2; i < 8; i++) push(p3[i]);
    wait_done(d + 1, 600, "t3_done");
    check("t3_acc", 32'(n_acc - b), 32);
    check("t3_conv", 32'(cap_d[b]), 32'h861F);
    check_frame(b, sb, "t3");

    // asynchronous reset during line 0, second repetition
    b = n_acc;
    for (int i = 0; i < 4; i++) push(p3[7 - i]);
    for (int c = 0; c < 300 && n_acc - b < 12; c++) @(negedge clk_w);
    check("t4_reach", 32'(n_acc - b >= 12), 1);
    check("t4_emit", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_outs_zero("t4_rst");
    @(negedge clk_w);
    rst_n = 1'b1;
    @(negedge clk_w);
    b = n_acc; d = n_done; sb = wr_ptr;
    for (int i = 0; i < 8; i++) push(24'h10_20_30 * 24'(i + 1) + 24'h0F0F0F);
    wait_done(d + 1, 600, "t4_done");
    check("t4_acc", 32'(n_acc - b), 32);
    check("t4_first_sof", 32'(cap_s[b]), 1);
    check_frame(b, sb, "t4");

    // two frames back to back
    b = n_acc; d = n_done; sb = wr_ptr; s = n_sof; e = n_eol;
    for (int i = 0; i < 16; i++) push(24'(i * 24'h0B1D27 + 24'h405060));
    wait_done(d + 2, 1500, "t5_done");
    check("t5_acc", 32'(n_acc - b), 64);
    check("t5_sof", 32'(n_sof - s), 2);
    check("t5_eol", 32'(n_eol - e), 8);
    check_frame(b, sb, "t5a");
    check_frame(b + 32, sb + 8, "t5b");
    check("t5_gap", 32'(max_gap <= 2), 1);
    check("rd_in_emit", 32'(rd_in_emit), 0);
    check("underflow", 32'(underflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
